// File: rtl/gs_dmem_responder_if.sv
// Data bus between the GS load/store unit and the data-memory responder.
//   mem_oe_i      read request strobe (LSU -> memory)
//   mem_web_i     byte write enables, bit n = lane n (LSU -> memory)
//   mem_addr_i    byte address, bits [1:0] ignored (LSU -> memory)
//   mem_data_i    lane-aligned write data (LSU -> memory)
//   mem_data_o    read data, held between completions (memory -> LSU)
//   mem_rvalid_o  one-cycle read completion pulse (memory -> LSU)
//   mem_err_o     access fault pulse (memory -> LSU)
// The signal names carry the memory-side direction suffix.
interface gs_dmem_responder_if;
  logic        mem_oe_i;
  logic [3:0]  mem_web_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_data_i;
  logic [31:0] mem_data_o;
  logic        mem_rvalid_o;
  logic        mem_err_o;

  modport master (
    output mem_oe_i, mem_web_i, mem_addr_i, mem_data_i,
    input  mem_data_o, mem_rvalid_o, mem_err_o
  );

  modport slave (
    input  mem_oe_i, mem_web_i, mem_addr_i, mem_data_i,
    output mem_data_o, mem_rvalid_o, mem_err_o
  );
endinterface

// File: rtl/gs_dmem_responder.sv
// Memory-side responder for the GS load/store unit data bus (data SRAM model).
// A DEPTH x 32-bit array takes byte-enabled writes and returns reads through a
// READ_LAT-stage pipeline with a one-cycle rvalid pulse.
// Ports:
//   clk  single clock, all state on posedge
//   rst  synchronous active-high reset (array contents are not reset)
//   bus  gs_dmem_responder_if.slave: oe/web/addr/wdata in, rdata/rvalid/err out
// Parameters:
//   DEPTH      words in the array, power of two, 2..2**29
//   BASE_ADDR  byte address of word 0, DEPTH*4 aligned
//   READ_LAT   edges from read request to rvalid, 1..3
// Build option: define GS_DMEM_BUSERR_EN to fault out-of-range accesses
// (reads return 32'hDEAD_BEEF with err, writes are dropped with an err pulse).
// Without it the address wraps modulo DEPTH and mem_err_o is tied low.
module gs_dmem_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned READ_LAT  = 1
) (
  input logic               clk,
  input logic               rst,
  gs_dmem_responder_if.slave bus
);

  localparam int unsigned IdxW = $clog2(DEPTH);

  logic [31:0]     offset;
  logic [IdxW-1:0] idx;
  logic            write_req;
  logic            read_req;
  logic            in_range;
  logic [31:0]     rd_word;
  logic            unused_offset;

  assign offset    = bus.mem_addr_i - BASE_ADDR;
  assign idx       = offset[IdxW+1:2];
  // Write wins over a simultaneous read request.
  assign write_req = |bus.mem_web_i;
  assign read_req  = bus.mem_oe_i & ~write_req;
  assign unused_offset = ^{offset[1:0], offset[31:IdxW+2]};

`ifdef GS_DMEM_BUSERR_EN
  // 33-bit span so BASE_ADDR + DEPTH*4 reaching 2**32 still compares correctly.
  localparam logic [32:0] Span = 33'(DEPTH) << 2;
  assign in_range = (bus.mem_addr_i >= BASE_ADDR) && ({1'b0, offset} < Span);
`else
  assign in_range = 1'b1;
`endif

  // Storage array, deliberately without reset.
  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst && write_req && in_range) begin
      for (int n = 0; n < 4; n++) begin
        if (bus.mem_web_i[n]) begin
          mem_q[idx][8*n +: 8] <= bus.mem_data_i[8*n +: 8];
        end
      end
    end
  end

  assign rd_word = in_range ? mem_q[idx] : 32'hDEAD_BEEF;

  // Read pipeline: stage 0 captures at the request edge, the last stage drives
  // the bus. Data only moves with a valid bit so the last stage holds the most
  // recent completion between pulses.
  logic [READ_LAT-1:0] vld_q, vld_d;
  logic [31:0]         data_q [READ_LAT];
  logic [31:0]         data_d [READ_LAT];

  always_comb begin
    vld_d     = '0;
    data_d    = data_q;
    vld_d[0]  = read_req;
    if (read_req) begin
      data_d[0] = rd_word;
    end
    for (int k = 1; k < int'(READ_LAT); k++) begin
      vld_d[k] = vld_q[k-1];
      if (vld_q[k-1]) begin
        data_d[k] = data_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int k = 0; k < int'(READ_LAT); k++) begin
        data_q[k] <= '0;
      end
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign bus.mem_data_o   = data_q[READ_LAT-1];
  assign bus.mem_rvalid_o = vld_q[READ_LAT-1];

`ifdef GS_DMEM_BUSERR_EN
  // Fault bit travels alongside each read; write faults get their own pulse.
  logic [READ_LAT-1:0] err_q, err_d;
  logic                werr_q;

  always_comb begin
    err_d    = err_q;
    if (read_req) begin
      err_d[0] = ~in_range;
    end
    for (int k = 1; k < int'(READ_LAT); k++) begin
      if (vld_q[k-1]) begin
        err_d[k] = err_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q  <= '0;
      werr_q <= 1'b0;
    end else begin
      err_q  <= err_d;
      werr_q <= write_req & ~in_range;
    end
  end

  assign bus.mem_err_o = (vld_q[READ_LAT-1] & err_q[READ_LAT-1]) | werr_q;
`else
  assign bus.mem_err_o = 1'b0;
`endif

endmodule
